// File: rtl/types_pkg.sv
// types_pkg: shared enums and default timing constants for the pipeline controller.
package types_pkg;
  localparam int MUL_CYC_DEF = 4;
  localparam int DRAIN_CYC_DEF = 2;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_S2 = 2'd1, FWD_S3 = 2'd2} fwd_sel_e;
  typedef enum logic [1:0] {RUN, MULBUSY, DRAIN, HALTED} pctrl_state_e;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: operand forwarding select and load-use hazard detect.
module fwd_unit
  import types_pkg::*;
(
  input  logic       s1_valid,
  input  logic [3:0] s1_rs1,
  input  logic [3:0] s1_rs2,
  input  logic [3:0] s2_rd,
  input  logic       s2_reg_wr,
  input  logic       s2_is_load,
  input  logic [3:0] s3_rd,
  input  logic       s3_reg_wr,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       load_use
);
  logic s2_alu;
  always_comb begin
    s2_alu = s2_reg_wr && !s2_is_load;
    fwd_a = (s2_alu && s2_rd == s1_rs1) ? FWD_S2 : (s3_reg_wr && s3_rd == s1_rs1) ? FWD_S3 : FWD_RF;
    fwd_b = (s2_alu && s2_rd == s1_rs2) ? FWD_S2 : (s3_reg_wr && s3_rd == s1_rs2) ? FWD_S3 : FWD_RF;
    load_use = s1_valid && s2_is_load && s2_reg_wr && (s2_rd == s1_rs1 || s2_rd == s1_rs2);
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/halt control FSM with forwarding and issue counter.
module pipe_ctrl
  import types_pkg::*;
#(
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s1_valid,
  input  logic [3:0]  s1_rs1,
  input  logic [3:0]  s1_rs2,
  input  logic        s1_is_mul,
  input  logic        s1_is_halt,
  input  logic [3:0]  s2_rd,
  input  logic        s2_reg_wr,
  input  logic        s2_is_load,
  input  logic [3:0]  s3_rd,
  input  logic        s3_reg_wr,
  input  logic        branch_taken,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall,
  output logic        flush,
  output logic        halt_sys,
  output logic [15:0] instr_count
);
  pctrl_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [15:0] count_q, count_d;
  logic load_use;
  fwd_unit u_fwd (
    .s1_valid(s1_valid), .s1_rs1(s1_rs1), .s1_rs2(s1_rs2),
    .s2_rd(s2_rd), .s2_reg_wr(s2_reg_wr), .s2_is_load(s2_is_load),
    .s3_rd(s3_rd), .s3_reg_wr(s3_reg_wr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use(load_use)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stall = 1'b0;
    flush = 1'b0;
    if (state_q == RUN) begin
      if (branch_taken) flush = 1'b1;
      else if (s1_valid && s1_is_halt) begin
        stall = 1'b1;
        cnt_d = 4'(DRAIN_CYC);
        state_d = DRAIN;
      end else if (s1_valid && s1_is_mul) begin
        cnt_d = 4'(MUL_CYC - 1);
        state_d = MULBUSY;
      end else if (load_use) stall = 1'b1;
    end else begin
      stall = 1'b1;
      if (state_q != HALTED) begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = (state_q == MULBUSY) ? RUN : HALTED;
      end
    end
    // Reset masks control outputs so nothing stale escapes while rst is held.
    stall = stall && !rst;
    flush = flush && !rst;
    count_d = (state_q == RUN && s1_valid && !stall && !flush && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      count_q <= count_d;
    end
  end
  assign halt_sys = (state_q == HALTED);
  assign instr_count = count_q;
endmodule
